// File: rtl/rgb_led_sequencer.sv
// rgb_led_sequencer: two-requester RGB fade-in / hold / fade-out sequencer with 8-bit PWM outputs.
// Optional feature: define RGB_SEQ_GAMMA_EN to apply a square-law gamma to the PWM compare duty.
module rgb_led_sequencer #(
  parameter int unsigned STEP_DIV    = 1024,
  parameter logic [31:0] HOLD_CYCLES = 32'd24000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid_i,
  input  logic [23:0] req_color0_i,
  input  logic [23:0] req_color1_i,
  output logic [1:0]  req_ready_o,
  output logic        pwm_red_o,
  output logic        pwm_green_o,
  output logic        pwm_blue_o,
  output logic        led_en_o,
  output logic        busy_o,
  output logic        owner_o,
  output logic        done_o
);
  typedef enum logic [1:0] {IDLE, FADE_IN, HOLD, FADE_OUT} state_e;
  localparam logic [19:0] DIV_MAX = 20'(STEP_DIV - 1);
  state_e      state_q;
  logic [7:0]  pwm_cnt_q;
  logic [23:0] cur_q, cur_d, target_q, xfer_color;
  logic [19:0] div_q;
  logic [31:0] hold_q;
  logic [2:0]  pwm_q;
  logic        owner_q, done_q, xfer, fade, tick, at_target, hold_end;
  // One saturating step toward the target; equal channels stay put, so 0 and 255 are never crossed.
  function automatic logic [7:0] step_toward(input logic [7:0] c, input logic [7:0] t);
    return (c < t) ? c + 8'd1 : (c > t) ? c - 8'd1 : c;
  endfunction
  // Compare duty derived from the current channel level.
  function automatic logic [7:0] duty(input logic [7:0] c);
`ifdef RGB_SEQ_GAMMA_EN
    logic [15:0] p;
    p = {8'd0, c} * {8'd0, c};
    return p[15:8];
`else
    return c;
`endif
  endfunction
  // Grant, transfer detect, step tick and next channel levels.
  always_comb begin
    req_ready_o = (rst_n && state_q != FADE_IN) ? {req_valid_i[1] & ~req_valid_i[0], req_valid_i[0]} : 2'b00;
    xfer        = |(req_valid_i & req_ready_o);
    xfer_color  = req_ready_o[0] ? req_color0_i : req_color1_i;
    fade        = state_q == FADE_IN || state_q == FADE_OUT;
    tick        = fade && div_q == DIV_MAX;
    at_target   = cur_q == target_q;
    hold_end    = HOLD_CYCLES <= 32'd1 || hold_q == HOLD_CYCLES - 32'd1;
    cur_d       = tick ? {step_toward(cur_q[23:16], target_q[23:16]),
                          step_toward(cur_q[15:8],  target_q[15:8]),
                          step_toward(cur_q[7:0],   target_q[7:0])} : cur_q;
  end
  // Sequencer state, fade levels and registered PWM / done outputs; a transfer overrides any state exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pwm_cnt_q <= '0;
      cur_q     <= '0;
      target_q  <= '0;
      div_q     <= '0;
      hold_q    <= '0;
      owner_q   <= 1'b0;
      done_q    <= 1'b0;
      pwm_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      pwm_q     <= {duty(cur_q[23:16]) > pwm_cnt_q, duty(cur_q[15:8]) > pwm_cnt_q, duty(cur_q[7:0]) > pwm_cnt_q};
      cur_q     <= cur_d;
      div_q     <= (fade && !tick) ? div_q + 20'd1 : '0;
      done_q    <= 1'b0;
      if (xfer) begin
        target_q <= xfer_color;
        owner_q  <= req_ready_o[1];
        div_q    <= '0;
        state_q  <= FADE_IN;
      end else begin
        case (state_q)
          FADE_IN: if (at_target) begin
            state_q <= HOLD;
            hold_q  <= '0;
          end
          HOLD: if (hold_end) begin
            state_q  <= FADE_OUT;
            target_q <= '0;
            div_q    <= '0;
          end else hold_q <= hold_q + 32'd1;
          FADE_OUT: if (at_target) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
  assign busy_o      = state_q != IDLE;
  assign led_en_o    = busy_o;
  assign owner_o     = owner_q;
  assign done_o      = done_q;
  assign pwm_red_o   = pwm_q[2];
  assign pwm_green_o = pwm_q[1];
  assign pwm_blue_o  = pwm_q[0];
endmodule

// File: tb/tb_rgb_led_sequencer.sv
// tb_rgb_led_sequencer: directed checks of reset, basic sequence, priority, preemption, PWM duty and mid-sequence reset.
module tb_rgb_led_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [23:0] req_color0 = '0, req_color1 = '0;
  logic [1:0]  req_ready;
  logic        pwm_red, pwm_green, pwm_blue, led_en, busy, owner, done;
  int          checks = 0, errors = 0;
  rgb_led_sequencer #(.STEP_DIV(4), .HOLD_CYCLES(32'd10)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_color0_i(req_color0), .req_color1_i(req_color1),
    .req_ready_o(req_ready), .pwm_red_o(pwm_red), .pwm_green_o(pwm_green), .pwm_blue_o(pwm_blue),
    .led_en_o(led_en), .busy_o(busy), .owner_o(owner), .done_o(done)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    step(2);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_color0 = 24'hFFFFFF;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", req_ready); end
    step(3);
    checks++; if ({busy, led_en, done, owner} !== 4'b0000) begin errors++; $display("FAIL reset_status got %b exp 0000", {busy, led_en, done, owner}); end
    checks++; if ({pwm_red, pwm_green, pwm_blue} !== 3'b000) begin errors++; $display("FAIL reset_pwm got %b exp 000", {pwm_red, pwm_green, pwm_blue}); end
    checks++; if (dut.cur_q !== 24'h0 || dut.state_q !== 2'd0) begin errors++; $display("FAIL reset_state got cur %h st %0d exp 0 0", dut.cur_q, dut.state_q); end
    req_valid = 2'b00;
    rst_n = 1'b1;
  endtask
  task automatic test_basic();
    int hold_n = 0, done_n = 0, k = 0;
    do_reset();
    req_color0 = 24'h030000;
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL basic_ready got %b exp 01", req_ready); end
    step(1);
    req_valid = 2'b00;
    checks++; if ({busy, led_en, owner} !== 3'b110) begin errors++; $display("FAIL basic_start got %b exp 110", {busy, led_en, owner}); end
    step(11);
    checks++; if (dut.cur_q[23:16] !== 8'd2) begin errors++; $display("FAIL basic_cur11 got %0d exp 2", dut.cur_q[23:16]); end
    step(1);
    checks++; if (dut.cur_q[23:16] !== 8'd3) begin errors++; $display("FAIL basic_cur12 got %0d exp 3", dut.cur_q[23:16]); end
    for (int i = 1; i <= 100; i++) begin
      step(1);
      if (dut.state_q == 2'd2) hold_n++;
      if (done) begin done_n++; k = i; break; end
    end
    checks++; if (k !== 24) begin errors++; $display("FAIL basic_done_time got %0d exp 24", k); end
    checks++; if (hold_n !== 10) begin errors++; $display("FAIL basic_hold_len got %0d exp 10", hold_n); end
    checks++; if ({busy, led_en} !== 2'b00) begin errors++; $display("FAIL basic_idle got %b exp 00", {busy, led_en}); end
    step(1);
    checks++; if (done !== 1'b0 || done_n !== 1) begin errors++; $display("FAIL basic_done_pulse got %b/%0d exp 0/1", done, done_n); end
  endtask
  task automatic test_priority();
    logic seen = 1'b0;
    do_reset();
    req_color0 = 24'h010000;
    req_color1 = 24'h000002;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL prio_ready got %b exp 01", req_ready); end
    step(1);
    req_valid = 2'b10;
    #1;
    checks++; if (owner !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL prio_fadein got owner %b ready %b exp 0 00", owner, req_ready); end
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (dut.state_q == 2'd2) begin seen = 1'b1; break; end
    end
    checks++; if (!seen || req_ready !== 2'b10) begin errors++; $display("FAIL prio_hold_grant got %b exp 10 (hold seen %b)", req_ready, seen); end
    step(1);
    req_valid = 2'b00;
    checks++; if (owner !== 1'b1 || dut.state_q !== 2'd1) begin errors++; $display("FAIL prio_owner1 got owner %b st %0d exp 1 1", owner, dut.state_q); end
  endtask
  task automatic test_preempt();
    logic seen = 1'b0;
    int done_n = 0;
    do_reset();
    req_color0 = 24'h030000;
    req_color1 = 24'h000005;
    req_valid = 2'b01;
    step(1);
    req_valid = 2'b00;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (dut.state_q == 2'd3 && dut.cur_q[23:16] == 8'd2) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL preempt_reach got %b exp 1", seen); end
    req_valid = 2'b10;
    step(1);
    req_valid = 2'b00;
    checks++; if (owner !== 1'b1 || dut.state_q !== 2'd1) begin errors++; $display("FAIL preempt_grant got owner %b st %0d exp 1 1", owner, dut.state_q); end
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (done) done_n++;
      if (dut.state_q == 2'd2) begin seen = 1'b1; break; end
    end
    checks++; if (!seen || done_n !== 0) begin errors++; $display("FAIL preempt_no_done got done %0d hold %b exp 0 1", done_n, seen); end
    checks++; if (dut.cur_q !== 24'h000005) begin errors++; $display("FAIL preempt_cur got %h exp 000005", dut.cur_q); end
  endtask
  task automatic test_pwm();
    logic seen = 1'b0;
    int r = 0, g = 0, b = 0;
    do_reset();
    req_color0 = 24'h80FF00;
    req_valid = 2'b01;
    for (int i = 0; i < 2000; i++) begin
      step(1);
      if (dut.cur_q == 24'h80FF00) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL pwm_reach got %h exp 80ff00", dut.cur_q); end
    step(3);
    for (int i = 0; i < 256; i++) begin
      r += int'(pwm_red);
      g += int'(pwm_green);
      b += int'(pwm_blue);
      step(1);
    end
    checks++; if (r !== 128) begin errors++; $display("FAIL pwm_red got %0d exp 128", r); end
    checks++; if (g !== 255) begin errors++; $display("FAIL pwm_green got %0d exp 255", g); end
    checks++; if (b !== 0) begin errors++; $display("FAIL pwm_blue got %0d exp 0", b); end
    req_valid = 2'b00;
  endtask
  task automatic test_reset_mid();
    logic seen = 1'b0;
    int done_n = 0;
    do_reset();
    req_color0 = 24'h030000;
    req_valid = 2'b01;
    step(1);
    req_valid = 2'b00;
    for (int i = 0; i < 50; i++) begin
      step(3);
      if (dut.state_q == 2'd2) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_hold got %b exp 1", seen); end
    req_valid = 2'b01;
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({req_ready, busy, led_en, done, owner, pwm_red, pwm_green, pwm_blue} !== 9'b0) begin errors++; $display("FAIL mid_outputs got %b exp 0", {req_ready, busy, led_en, done, owner, pwm_red, pwm_green, pwm_blue}); end
    checks++; if (dut.state_q !== 2'd0 || dut.cur_q !== 24'h0) begin errors++; $display("FAIL mid_state got st %0d cur %h exp 0 0", dut.state_q, dut.cur_q); end
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (done) done_n++;
    end
    checks++; if (done_n !== 0) begin errors++; $display("FAIL mid_no_done got %0d exp 0", done_n); end
    rst_n = 1'b1;
    step(1);
    checks++; if (busy !== 1'b1 || dut.cur_q !== 24'h0) begin errors++; $display("FAIL mid_first_xfer got busy %b cur %h exp 1 0", busy, dut.cur_q); end
    req_valid = 2'b00;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_preempt();
    test_pwm();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rgb_led_sequencer.md
RGB_LED_SEQUENCER -- requirements
Module: rgb_led_sequencer

Interface
REQ-001 Parameter STEP_DIV, default 1024: clocks per fade step, legal range 1..2^20.
REQ-002 Parameter HOLD_CYCLES, default 24000000: clocks spent in HOLD, legal range 0..2^32-1.
REQ-003 clk  input  1  single clock for the whole block.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  2  bit i high = requester i offers a colour.
REQ-006 req_color0 / req_color1  input  24 each  {R[23:16],G[15:8],B[7:0]} target duty for requester 0 / 1.
REQ-007 req_ready  output  2  one-hot grant; transfer on req_valid[i] & req_ready[i].
REQ-008 pwm_red, pwm_green, pwm_blue  output  1 each  PWM inputs for the RGB current driver.
REQ-009 led_en  output  1  driver enable.
REQ-010 busy  output  1  high in any state except IDLE.
REQ-011 owner  output  1  index of the last accepted requester.
REQ-012 done  output  1  one-cycle pulse when a sequence completes.

Function
REQ-013 An 8-bit pwm_cnt increments every clk and wraps from 255 to 0.
REQ-014 pwm_x is registered as (duty_x > pwm_cnt): duty 0 keeps it always low, duty 255 gives 255/256 high.
REQ-015 The state machine has four states: IDLE, FADE_IN, HOLD, FADE_OUT.
REQ-016 req_ready is combinational; it is all-zero in FADE_IN.
- In other states, req_ready[0] = req_valid[0].
- In other states, req_ready[1] = req_valid[1] & ~req_valid[0] (fixed priority to 0).
REQ-017 On a transfer:
- latch target = granted colour and owner = i;
- clear the step divider;
- enter FADE_IN next cycle.
- Current duties (cur_r/g/b) are kept, so preemption fades from the present colour.
REQ-018 In FADE_IN and FADE_OUT, a step tick fires every STEP_DIV clocks.
- On each tick, every cur_x moves by 1 toward its target.
- Channels already equal to their target do not move.
REQ-019 FADE_IN leaves for HOLD on the cycle after cur equals target on all channels; this includes entry with cur already equal.
- The hold counter clears on entry to HOLD.
REQ-020 HOLD lasts max(HOLD_CYCLES,1) clocks, then sets target to 0 and enters FADE_OUT.
REQ-021 When FADE_OUT reaches cur=0 on all channels, the block pulses done for one cycle and enters IDLE.
REQ-022 A transfer in the cycle FADE_OUT would complete takes priority: enter FADE_IN, no done pulse.
REQ-023 A transfer in HOLD or FADE_OUT aborts the current sequence without a done pulse.
REQ-024 led_en = busy, registered alongside the state.
REQ-025 The cur_x arithmetic never wraps; 0 and 255 are hard limits.

Reset
REQ-026 While rst_n is low, all of the following are zero: state=IDLE, pwm_cnt, cur, target, divider, hold counter, owner.
REQ-027 While rst_n is low, pwm_*, led_en, busy, done and req_ready are all 0.
REQ-028 Reset asserted mid-sequence aborts the sequence immediately, with no done pulse.
REQ-029 The first transfer is possible on the first clk edge after rst_n rises.

Configuration
REQ-030 With RGB_SEQ_GAMMA_EN defined, the compare duty is duty_x = (cur_x*cur_x)>>8, a 16-bit product taking the upper byte.
REQ-031 Without RGB_SEQ_GAMMA_EN, duty_x = cur_x.
REQ-032 Fade timing, state transitions and cur values are identical with and without RGB_SEQ_GAMMA_EN.

Verification
REQ-033 Verification parameters for all scenarios: STEP_DIV=4, HOLD_CYCLES=10, macro undefined.
REQ-034 Basic sequence.
- Stimulus: req_valid=01, req_color0=0x030000.
- Response: FADE_IN takes 12 clocks, cur_r=3; HOLD for 10 clocks; FADE_OUT takes 12 clocks; one done pulse; then idle with led_en=0.
REQ-035 Priority.
- Stimulus: req_valid=11 in IDLE.
- Response: req_ready=01 and owner=0; requester 1 stays pending and is granted in HOLD if req_valid[0] is low.
REQ-036 Preemption.
- Stimulus: during FADE_OUT at cur_r=2, requester 1 sends 0x000005.
- Response: no done pulse; cur_r falls to 0 while cur_b rises to 5; owner=1.
REQ-037 PWM duty.
- Stimulus: hold cur at 0x80 / 0xFF / 0x00.
- Response: pwm high for 128 / 255 / 0 of 256 clocks.
- With RGB_SEQ_GAMMA_EN defined, cur=0x80 gives 64 of 256.
REQ-038 Reset.
- Stimulus: drop rst_n in HOLD.
- Response: all outputs 0 within the same cycle, state IDLE, no done pulse.
